uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter in front of a uart_core TX FIFO.
// Bytes are loaded into the FIFO, a send is kicked off, and the arbiter waits for tx_done.
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] tx_data_in,
    output logic       tx_data_in_en,
    output logic       tx_send,
    input  logic       tx_done,
    input  logic       tx_fifo_overflow,
    output logic       grant,
    output logic       busy,
    output logic       err_overflow,
    output logic       err_timeout
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] SEND      = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic          grant_reg, grant_next;
    logic          last_grant_reg, last_grant_next;
    logic [FW-1:0] fill_reg, fill_next;
    logic [WW-1:0] wait_reg, wait_next;
    logic          pkt_end_reg, pkt_end_next;
    logic          done_prev_reg;
    logic [7:0]    data_reg, data_next;
    logic          data_en_reg, data_en_next;
    logic          err_ovf_reg, err_ovf_next;
    logic          err_to_reg, err_to_next;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       accept;
    logic       done_rise;

    assign req_valid = {req1_valid, req0_valid};

    // Only the granted requester ever sees ready, and only while the FIFO has room.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == LOAD) && (grant_reg == 1'(gi))
                                   && (fill_reg < FILL_MAX);
        end
    endgenerate

    assign sel_valid = grant_reg ? req1_valid : req0_valid;
    assign sel_data  = grant_reg ? req1_data  : req0_data;
    assign sel_last  = grant_reg ? req1_last  : req0_last;
    assign accept    = sel_valid && req_ready[grant_reg];
    assign done_rise = tx_done && !done_prev_reg;

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        fill_next       = fill_reg;
        wait_next       = wait_reg;
        pkt_end_next    = pkt_end_reg;
        data_next       = data_reg;
        data_en_next    = 1'b0;
        err_ovf_next    = err_ovf_reg | tx_fifo_overflow;
        err_to_next     = err_to_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    grant_next = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];
                    fill_next  = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    data_next    = sel_data;
                    data_en_next = 1'b1;
                    fill_next    = fill_reg + FW'(1);
                    if (sel_last) begin
                        pkt_end_next = 1'b1;
                        state_next   = SEND;
                    end else if (fill_reg + FW'(1) == FILL_MAX) begin
                        pkt_end_next = 1'b0;
                        state_next   = SEND;
                    end
                end
            end
            SEND: begin
                wait_next  = '0;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done edge wins over an expiring timeout in the same cycle.
                if (done_rise) begin
                    fill_next = '0;
                    if (pkt_end_reg) begin
                        last_grant_next = grant_reg;
                        state_next      = IDLE;
                    end else begin
                        state_next = LOAD;
                    end
                end else if (wait_reg == WAIT_MAX) begin
                    err_to_next     = 1'b1;
                    last_grant_next = grant_reg;
                    state_next      = IDLE;
                end else begin
                    wait_next = wait_reg + WW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            fill_reg       <= '0;
            wait_reg       <= '0;
            pkt_end_reg    <= 1'b0;
            done_prev_reg  <= 1'b0;
            data_reg       <= 8'h00;
            data_en_reg    <= 1'b0;
            err_ovf_reg    <= 1'b0;
            err_to_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            fill_reg       <= fill_next;
            wait_reg       <= wait_next;
            pkt_end_reg    <= pkt_end_next;
            done_prev_reg  <= tx_done;
            data_reg       <= data_next;
            data_en_reg    <= data_en_next;
            err_ovf_reg    <= err_ovf_next;
            err_to_reg     <= err_to_next;
        end
    end

    assign req0_ready    = req_ready[0];
    assign req1_ready    = req_ready[1];
    assign tx_data_in    = data_reg;
    assign tx_data_in_en = data_en_reg;
    assign tx_send       = (state_reg == SEND);
    assign grant         = grant_reg;
    assign busy          = (state_reg != IDLE);
    assign err_overflow  = err_ovf_reg;
    assign err_timeout   = err_to_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single packet, round-robin ties, FIFO-sized
// splitting of a long packet, tx_done timeout, overflow flag and mid-packet reset.
module tb_uart_tx_arbiter;

    localparam int DEPTH = 16;
    localparam int TMO   = 8;

    logic       clk, reset_n;
    logic       req0_valid, req0_last, req0_ready;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic [7:0] tx_data_in;
    logic       tx_data_in_en, tx_send, tx_done, tx_fifo_overflow;
    logic       grant, busy, err_overflow, err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int send_cnt = 0;
    logic [8:0] wr_q[$];      // {grant, data} of every FIFO write
    logic       grants_q[$];  // grant seen when busy rises
    logic [8:0] q0[$], q1[$]; // {last, data} pending per requester

    uart_tx_arbiter #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx_data_in(tx_data_in), .tx_data_in_en(tx_data_in_en), .tx_send(tx_send),
        .tx_done(tx_done), .tx_fifo_overflow(tx_fifo_overflow),
        .grant(grant), .busy(busy), .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requester sources: present the queue head, pop it after a handshake.
    initial begin
        bit hs0, hs1;
        req0_valid = 0; req0_data = 0; req0_last = 0;
        req1_valid = 0; req1_data = 0; req1_last = 0;
        forever begin
            @(negedge clk);
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (hs0 && q0.size() > 0) void'(q0.pop_front());
            if (hs1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin req0_valid = 1; {req0_last, req0_data} = q0[0]; end
            else begin req0_valid = 0; req0_last = 0; req0_data = 0; end
            if (q1.size() > 0) begin req1_valid = 1; {req1_last, req1_data} = q1[0]; end
            else begin req1_valid = 0; req1_last = 0; req1_data = 0; end
        end
    end

    initial begin
        bit busy_prev;
        busy_prev = 0;
        forever begin
            @(negedge clk);
            if (tx_data_in_en) begin
                wr_q.push_back({grant, tx_data_in});
                $display("write grant=%0d data=%02h", grant, tx_data_in);
            end
            if (tx_send) begin
                send_cnt++;
                $display("send grant=%0d", grant);
            end
            if (busy && !busy_prev) grants_q.push_back(grant);
            busy_prev = busy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no end expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic wait_send(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_send) begin ok = 1; break; end
        end
    endtask

    task automatic pulse_done;
        @(posedge clk); #1 tx_done = 1;
        @(posedge clk); #1 tx_done = 0;
    endtask

    task automatic test_reset;
        reset_n = 0; tx_done = 0; tx_fifo_overflow = 0;
        #1;
        n_checks++;
        if ({tx_data_in, tx_data_in_en, tx_send, grant, busy, req0_ready, req1_ready, err_overflow, err_timeout} !== 16'h0) begin
            n_fail++; $display("FAIL reset_async: got %h expected 0000",
                {tx_data_in, tx_data_in_en, tx_send, grant, busy, req0_ready, req1_ready, err_overflow, err_timeout});
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({tx_data_in, tx_data_in_en, tx_send, grant, busy} !== 12'h0) begin
            n_fail++; $display("FAIL reset_clocked: got %h expected 000", {tx_data_in, tx_data_in_en, tx_send, grant, busy});
        end
    endtask

    task automatic test_tie;
        bit ok;
        logic [8:0] exp_w[6];
        logic       exp_g[6];
        exp_w = '{9'h0A0, 9'h1B0, 9'h0A1, 9'h1B1, 9'h0A2, 9'h1B2};
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        q0.push_back(9'h1A0); q0.push_back(9'h1A1); q0.push_back(9'h1A2);
        q1.push_back(9'h1B0); q1.push_back(9'h1B1); q1.push_back(9'h1B2);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({req0_valid, req1_valid, req0_ready, req1_ready} !== 4'b1100) begin
            n_fail++; $display("FAIL tie_ready_in_reset: got %b expected 1100", {req0_valid, req1_valid, req0_ready, req1_ready});
        end
        reset_n = 1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, grant} !== 2'b10) begin
            n_fail++; $display("FAIL first_grant: got busy,grant=%b expected 10", {busy, grant});
        end
        for (int r = 0; r < 6; r++) begin
            wait_send(ok);
            n_checks++;
            if (!ok || req0_ready || req1_ready) begin
                n_fail++; $display("FAIL tie_send_%0d: got sent=%0d ready=%b%b expected sent=1 ready=00", r, ok, req0_ready, req1_ready);
            end
            pulse_done();
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= wr_q.size() || wr_q[i] !== exp_w[i] || i >= grants_q.size() || grants_q[i] !== exp_g[i]) begin
                n_fail++; $display("FAIL tie_order_%0d: got write=%h grant=%b expected write=%h grant=%b", i,
                    (i < wr_q.size()) ? wr_q[i] : 9'h1FF, (i < grants_q.size()) ? grants_q[i] : 1'bx, exp_w[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_single;
        bit ok;
        wr_q.delete(); grants_q.delete(); send_cnt = 0;
        q0.push_back(9'h041); q0.push_back(9'h042); q0.push_back(9'h143);
        wait_send(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_send: got none expected tx_send"); end
        @(posedge clk); #1;
        n_checks++;
        if ({tx_send, busy} !== 2'b01) begin
            n_fail++; $display("FAIL single_send_width: got send,busy=%b expected 01", {tx_send, busy});
        end
        @(posedge clk); #1 tx_done = 1;
        @(posedge clk); #1 tx_done = 0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
        n_checks++;
        if (wr_q.size() != 3 || wr_q[0] !== 9'h041 || wr_q[1] !== 9'h042 || wr_q[2] !== 9'h043 || send_cnt != 1) begin
            n_fail++; $display("FAIL single_data: got %0d writes first=%h last=%h sends=%0d expected 3 writes 041..043 sends=1",
                wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 9'h1FF, (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : 9'h1FF, send_cnt);
        end
    endtask

    task automatic test_long;
        bit ok;
        int bad;
        wr_q.delete(); grants_q.delete(); send_cnt = 0;
        for (int i = 0; i < 20; i++) q1.push_back({(i == 19) ? 1'b1 : 1'b0, 8'(8'h10 + i)});
        wait_send(ok);
        n_checks++;
        if (!ok || req1_ready !== 1'b0 || grant !== 1'b1) begin
            n_fail++; $display("FAIL long_send1: got sent=%0d ready=%b grant=%b expected sent=1 ready=0 grant=1", ok, req1_ready, grant);
        end
        @(posedge clk); #1;
        n_checks++;
        if (wr_q.size() != 16 || req1_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL long_first_load: got writes=%0d ready=%b busy=%b expected 16 0 1", wr_q.size(), req1_ready, busy);
        end
        @(posedge clk); #1 tx_done = 1;
        @(posedge clk); #1 tx_done = 0;
        n_checks++;
        if ({busy, grant} !== 2'b11) begin
            n_fail++; $display("FAIL long_continue: got busy,grant=%b expected 11", {busy, grant});
        end
        wait_send(ok);
        n_checks++;
        if (!ok || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL long_send2: got sent=%0d ready=%b expected 1 0", ok, req1_ready);
        end
        pulse_done();
        bad = 0;
        for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== {1'b1, 8'(8'h10 + i)}) bad++;
        n_checks++;
        if (busy !== 1'b0 || wr_q.size() != 20 || bad != 0 || send_cnt != 2 || grants_q.size() != 1) begin
            n_fail++; $display("FAIL long_result: got busy=%b writes=%0d bad=%0d sends=%0d grants=%0d expected 0 20 0 2 1",
                busy, wr_q.size(), bad, send_cnt, grants_q.size());
        end
    endtask

    task automatic test_timeout;
        bit ok;
        wr_q.delete(); send_cnt = 0;
        q1.push_back(9'h177);
        wait_send(ok);
        q0.push_back(9'h155);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL timeout_send: got none expected tx_send"); end
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if ({err_timeout, busy} !== 2'b01) begin
            n_fail++; $display("FAIL timeout_early: got err,busy=%b expected 01", {err_timeout, busy});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({err_timeout, busy} !== 2'b10) begin
            n_fail++; $display("FAIL timeout_fire: got err,busy=%b expected 10", {err_timeout, busy});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({busy, grant} !== 2'b10) begin
            n_fail++; $display("FAIL timeout_next_grant: got busy,grant=%b expected 10", {busy, grant});
        end
        wait_send(ok);
        pulse_done();
        n_checks++;
        if (!ok || wr_q.size() != 2 || wr_q[1] !== 9'h055 || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pending_pkt: got sent=%0d writes=%0d busy=%b expected 1 2 0", ok, wr_q.size(), busy);
        end
    endtask

    task automatic test_fault_reset;
        @(posedge clk); #1 tx_fifo_overflow = 1;
        @(posedge clk); #1 tx_fifo_overflow = 0;
        @(posedge clk); #1;
        n_checks++;
        if ({err_overflow, err_timeout, busy} !== 3'b110) begin
            n_fail++; $display("FAIL overflow_flag: got ovf,to,busy=%b expected 110", {err_overflow, err_timeout, busy});
        end
        wr_q.delete(); send_cnt = 0;
        for (int i = 0; i < 5; i++) q0.push_back({(i == 4) ? 1'b1 : 1'b0, 8'(8'hC1 + i)});
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #3;
            if (wr_q.size() >= 2) break;
        end
        reset_n = 0;
        #1;
        n_checks++;
        if ({tx_data_in, tx_data_in_en, tx_send, grant, busy, req0_ready, req1_ready, err_overflow, err_timeout} !== 16'h0
            || wr_q.size() != 2) begin
            n_fail++; $display("FAIL reset_mid_packet: got outs=%h writes=%0d expected 0000 2",
                {tx_data_in, tx_data_in_en, tx_send, grant, busy, req0_ready, req1_ready, err_overflow, err_timeout}, wr_q.size());
        end
        q0.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (send_cnt != 0 || busy !== 1'b0 || wr_q.size() != 2) begin
            n_fail++; $display("FAIL reset_no_send: got sends=%0d busy=%b writes=%0d expected 0 0 2", send_cnt, busy, wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_long();
        test_timeout();
        test_fault_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
